// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared definitions for the multiply/divide unit.
//   - FSM state constants (MDU_IDLE/MUL/DIV/DONE) and state/counter types
//   - MULT/MULTU/DIV/DIVU funct encodings
//   - decode_funct(): classifies a funct field
//   - abs_if(): magnitude of a value when treated as signed
package mult_div_pkg;

  typedef logic [1:0]  mdu_state_t;
  typedef logic [5:0]  mdu_cnt_t;
  typedef logic [5:0]  funct_t;

  localparam mdu_state_t MDU_IDLE = 2'd0;
  localparam mdu_state_t MDU_MUL  = 2'd1;
  localparam mdu_state_t MDU_DIV  = 2'd2;
  localparam mdu_state_t MDU_DONE = 2'd3;

  localparam funct_t FUNCT_MULT  = 6'b011000;
  localparam funct_t FUNCT_MULTU = 6'b011001;
  localparam funct_t FUNCT_DIV   = 6'b011010;
  localparam funct_t FUNCT_DIVU  = 6'b011011;

  typedef struct packed {
    logic valid;
    logic is_div;
    logic is_signed;
  } md_op_t;

  function automatic md_op_t decode_funct(funct_t f);
    md_op_t op;
    op = '0;
    unique case (f)
      FUNCT_MULT:  op = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b1};
      FUNCT_MULTU: op = '{valid: 1'b1, is_div: 1'b0, is_signed: 1'b0};
      FUNCT_DIV:   op = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b1};
      FUNCT_DIVU:  op = '{valid: 1'b1, is_div: 1'b1, is_signed: 1'b0};
      default:     op = '0;
    endcase
    return op;
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_if(logic [31:0] v, logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: EX-stage <-> multiply/divide unit bundle.
//   funct, operand_1, operand_2 : request from the ID/EX register
//   flush, stall                : pipeline control
//   done, result                : response ({hi, lo})
// Modports: master (EX side), slave (mult_div).
interface mult_div_if;

  mult_div_pkg::funct_t funct;
  logic [31:0]          operand_1;
  logic [31:0]          operand_2;
  logic                 flush;
  logic                 stall;
  logic                 done;
  logic [63:0]          result;

  modport master (
    output funct, operand_1, operand_2, flush, stall,
    input  done, result
  );

  modport slave (
    input  funct, operand_1, operand_2, flush, stall,
    output done, result
  );

endinterface

// File: rtl/mult_div_div_core.sv
// mult_div_div_core (div_core): unsigned radix-2 restoring divider.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : load dividend/divisor and begin
//   abort_i                : drop any operation in flight
//   dividend_i, divisor_i  : unsigned operands (divisor must be non-zero)
//   busy_o                 : iterating
//   valid_o                : final iteration this cycle; quotient_o/remainder_o are the answer
//   quotient_o, remainder_o: result of the current iteration step
module mult_div_div_core
  import mult_div_pkg::*;
#(
  parameter int unsigned Cycles = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        busy_q, busy_d;
  mdu_cnt_t    cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic        last;

  // diff[32] set means the trial subtraction went negative: restore.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    rem_step = diff[32] ? shifted[31:0] : diff[31:0];
    quo_step = {quo_q[30:0], ~diff[32]};
    last     = busy_q && (cnt_q == mdu_cnt_t'(Cycles - 1));
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + 6'd1;
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = last;
  assign quotient_o  = quo_step;
  assign remainder_o = rem_step;

endmodule

// File: rtl/mult_div.sv
// mult_div: multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX stage.
//   clk    : core clock
//   rst    : asynchronous active-low reset
//   bus    : mult_div_if.slave (funct, operand_1/2, flush, stall in; done, result out)
// Divides use the restoring divider sub-module; multiplies use an iterative shift-add
// datapath, or a single-cycle multiplier when MDU_FAST_MULT_EN is defined.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  mult_div_if.slave  bus
);

  md_op_t      op;
  logic [31:0] abs_1, abs_2;

  assign op    = decode_funct(bus.funct);
  assign abs_1 = abs_if(bus.operand_1, op.is_signed);
  assign abs_2 = abs_if(bus.operand_2, op.is_signed);

  mdu_state_t  state_q, state_d;
  logic        done_q, done_d;
  logic [63:0] result_q, result_d;
  logic        quo_neg_q, quo_neg_d;  // quotient / product negated
  logic        rem_neg_q, rem_neg_d;  // remainder takes dividend sign

  logic        div_start;
  logic        div_busy;
  logic        div_valid;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, abs_1} * {32'd0, abs_2};
`else
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  mdu_cnt_t    cnt_q, cnt_d;
  logic [63:0] prod_step;
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif

  mult_div_div_core #(
    .Cycles (DIV_CYCLES)
  ) u_div_core (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (div_start),
    .abort_i     (bus.flush),
    .dividend_i  (abs_1),
    .divisor_i   (abs_2),
    .busy_o      (div_busy),
    .valid_o     (div_valid),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div_start = 1'b0;
`ifndef MDU_FAST_MULT_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
`endif

    case (state_q)
      MDU_IDLE: begin
        if (op.valid && !bus.flush) begin
          quo_neg_d = op.is_signed & (bus.operand_1[31] ^ bus.operand_2[31]);
          rem_neg_d = op.is_signed & bus.operand_1[31];
          if (op.is_div) begin
            if (bus.operand_2 == 32'd0) begin
              result_d = {bus.operand_1, 32'hFFFF_FFFF};
              state_d  = MDU_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = MDU_DIV;
            end
          end else begin
`ifdef MDU_FAST_MULT_EN
            result_d = quo_neg_d ? (~fast_prod + 64'd1) : fast_prod;
            state_d  = MDU_DONE;
`else
            mcand_d  = {32'd0, abs_1};
            mplier_d = abs_2;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = MDU_MUL;
`endif
          end
        end
      end

      MDU_MUL: begin
`ifdef MDU_FAST_MULT_EN
        state_d = MDU_IDLE;
`else
        prod_d   = prod_step;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == mdu_cnt_t'(DIV_CYCLES - 1)) begin
          result_d = quo_neg_q ? (~prod_step + 64'd1) : prod_step;
          state_d  = MDU_DONE;
        end
`endif
      end

      MDU_DIV: begin
        if (div_valid) begin
          result_d = {rem_neg_q ? (~div_rem + 32'd1) : div_rem,
                      quo_neg_q ? (~div_quo + 32'd1) : div_quo};
          state_d  = MDU_DONE;
        end else if (!div_busy) begin
          // Divider lost its operation; never wait forever.
          state_d = MDU_IDLE;
        end
      end

      MDU_DONE: begin
        if (!bus.stall) state_d = MDU_IDLE;
      end

      default: state_d = MDU_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle trigger.
    if (bus.flush) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
    end

    done_d = (state_d == MDU_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MDU_IDLE;
      done_q    <= 1'b0;
      result_q  <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
`ifndef MDU_FAST_MULT_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      result_q  <= result_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
`ifndef MDU_FAST_MULT_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
